// File: rtl/mx_exp_expand_if.sv
// rtl/mx_exp_expand_if.sv - handshake bundle for the MX shared-exponent expander
interface mx_exp_expand_if #(
   parameter int width       = 8,
   parameter int scale_width = 8,
   parameter int lanes       = 4
);
   localparam int out_width = ((width > scale_width) ? width : scale_width) + 1;

   // shared scale channel
   logic                   i_scale_valid;
   logic                   o_scale_ready;
   logic [scale_width-1:0] i_scale;

   // element exponent channel
   logic                   i_elem_valid;
   logic                   o_elem_ready;
   logic [width-1:0]       i_elem_exps [lanes];

   // expanded output channel
   logic                   o_valid;
   logic                   i_ready;
   logic [out_width-1:0]   o_exps [lanes];
   logic                   o_nan;
   logic                   o_last;

   // expander side
   modport slave (
      input  i_scale_valid, i_scale, i_elem_valid, i_elem_exps, i_ready,
      output o_scale_ready, o_elem_ready, o_valid, o_exps, o_nan, o_last
   );

   // environment side (upstream block storage and downstream consumer)
   modport master (
      output i_scale_valid, i_scale, i_elem_valid, i_elem_exps, i_ready,
      input  o_scale_ready, o_elem_ready, o_valid, o_exps, o_nan, o_last
   );
endinterface

// File: rtl/mx_exp_expand.sv
// rtl/mx_exp_expand.sv - streaming MX shared-exponent expander with NaN/zero propagation
module mx_exp_expand #(
   parameter int width       = 8,
   parameter int scale_width = 8,
   parameter int length      = 32,
   parameter int lanes       = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   mx_exp_expand_if.slave     bus
);
   localparam int beats     = length / lanes;
   localparam int cnt_width = (beats > 1) ? $clog2(beats) : 1;
   localparam int out_width = ((width > scale_width) ? width : scale_width) + 1;

   localparam logic [cnt_width-1:0] last_cnt = cnt_width'(beats - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ELEM = 1'b1;

   logic [0:0]             r_state;
   logic [scale_width-1:0] r_scale;
   logic [cnt_width-1:0]   r_cnt;

   logic                   r_valid;
   logic                   r_nan;
   logic                   r_last;
   logic [out_width-1:0]   r_exps [lanes];

   logic                   w_scale_ready;
   logic                   w_elem_ready;
   logic                   w_scale_fire;
   logic                   w_elem_fire;
   logic                   w_last_beat;
   logic                   w_scale_nan;
   logic [out_width-1:0]   w_exps [lanes];

   // handshake decode; i_ready -> o_elem_ready is the only input-to-output path
   always_comb begin
      w_scale_ready = (r_state == S_IDLE);
      w_elem_ready  = (r_state == S_ELEM) && (!r_valid || bus.i_ready);
      w_scale_fire  = w_scale_ready && bus.i_scale_valid;
      w_elem_fire   = w_elem_ready && bus.i_elem_valid;
      w_last_beat   = (r_cnt == last_cnt);
      w_scale_nan   = &r_scale;
   end

   // per-lane expansion: NaN scale dominates, zero element passes through unscaled
   always_comb begin
      for (int k = 0; k < lanes; k++) begin
         w_exps[k] = '0;
         if (w_scale_nan) begin
            w_exps[k] = '1;
         end else if (bus.i_elem_exps[k] != '0) begin
            w_exps[k] = out_width'(r_scale) + out_width'(bus.i_elem_exps[k]);
         end
      end
   end

   // block sequencing: take one scale, then count beats until the block's last beat
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_scale <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_scale_fire) begin
                  r_scale <= bus.i_scale;
                  r_cnt   <= '0;
                  r_state <= S_ELEM;
               end
            end
            S_ELEM: begin
               if (w_elem_fire) begin
                  if (w_last_beat) begin
                     r_cnt   <= '0;
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // output register: load on accepted beat, drain on downstream take, hold otherwise
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_nan   <= 1'b0;
         r_last  <= 1'b0;
         for (int k = 0; k < lanes; k++) begin
            r_exps[k] <= '0;
         end
      end else if (w_elem_fire) begin
         r_valid <= 1'b1;
         r_nan   <= w_scale_nan;
         r_last  <= w_last_beat;
         for (int k = 0; k < lanes; k++) begin
            r_exps[k] <= w_exps[k];
         end
      end else if (r_valid && bus.i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign bus.o_scale_ready = w_scale_ready;
   assign bus.o_elem_ready  = w_elem_ready;
   assign bus.o_valid       = r_valid;
   assign bus.o_nan         = r_nan;
   assign bus.o_last        = r_last;
   assign bus.o_exps        = r_exps;
endmodule
